// File: rtl/vending_coin_arbiter_if.sv
// Coin-slot, vending-FSM and sale-report signals of vending_coin_arbiter.
// master = slots plus vending FSM side; slave = the arbiter.
interface vending_coin_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_dime;
  logic [N_REQ-1:0] req_ready;
  logic             vm_nickel;
  logic             vm_dime;
  logic             vm_dispense;
  logic             done_valid;
  logic [ID_W-1:0]  done_id;
  logic             done_change;
  logic             busy;
  logic             err;

  modport master (
    output req_valid, req_dime, vm_dispense,
    input  req_ready, vm_nickel, vm_dime, done_valid, done_id, done_change, busy, err
  );

  modport slave (
    input  req_valid, req_dime, vm_dispense,
    output req_ready, vm_nickel, vm_dime, done_valid, done_id, done_change, busy, err
  );
endinterface

// File: rtl/vending_coin_arbiter.sv
// Round-robin share of one 20-cent nickel/dime vending FSM between N_REQ coin slots.
// The winning slot owns the machine until its sale dispenses; err is sticky until reset.
module vending_coin_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 2,
  parameter int DISP_TIMEOUT = 4
) (
  input logic                  clock,
  input logic                  reset,
  vending_coin_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(DISP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_DISP} state_t;

  state_t           state;
  state_t           state_next;
  logic [2:0]       credit;
  logic [2:0]       new_credit;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic             change_latch;
  logic [N_REQ-1:0] ready;
  logic             accept;
  logic             accept_dime;
  logic             vm_nickel;
  logic             vm_dime;
  logic             done_valid;
  logic [ID_W-1:0]  done_id;
  logic             done_change;
  logic             err;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // First requesting slot at or after rr_ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[wrap_add(rr_ptr, k)]) begin
        found  = 1'b1;
        winner = wrap_add(rr_ptr, k);
      end
    end
  end

  always_comb begin
    ready = '0;
    case (state)
      IDLE:    if (found) ready[winner] = 1'b1;
      ACTIVE:  ready[owner] = 1'b1;
      default: ready = '0;
    endcase
  end

  assign accept      = |(bus.req_valid & ready);
  assign accept_dime = |(bus.req_valid & bus.req_dime & ready);
  assign timeout     = (wait_cnt == CNT_W'(DISP_TIMEOUT));

  always_comb begin
    state_next = state;
    new_credit = credit + (accept_dime ? 3'd2 : 3'd1);
    case (state)
      IDLE:      if (accept) state_next = ACTIVE;
      ACTIVE:    if (accept && new_credit >= 3'd4) state_next = WAIT_DISP;
      WAIT_DISP: if (bus.vm_dispense || timeout) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      credit       <= '0;
      owner        <= '0;
      rr_ptr       <= '0;
      wait_cnt     <= '0;
      change_latch <= 1'b0;
      vm_nickel    <= 1'b0;
      vm_dime      <= 1'b0;
      done_valid   <= 1'b0;
      done_id      <= '0;
      done_change  <= 1'b0;
      err          <= 1'b0;
    end else begin
      vm_nickel   <= accept & ~accept_dime;
      vm_dime     <= accept & accept_dime;
      done_valid  <= 1'b0;
      done_id     <= '0;
      done_change <= 1'b0;
      // A dispense outside WAIT_DISP means the downstream FSM is out of step with us.
      if (state != WAIT_DISP && bus.vm_dispense) err <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            owner  <= winner;
            rr_ptr <= wrap_add(winner, 1);
            credit <= accept_dime ? 3'd2 : 3'd1;
          end
        end
        ACTIVE: begin
          if (accept) begin
            credit       <= new_credit;
            wait_cnt     <= '0;
            change_latch <= (new_credit == 3'd5);
          end
        end
        WAIT_DISP: begin
          if (bus.vm_dispense) begin
            done_valid  <= 1'b1;
            done_id     <= owner;
            done_change <= change_latch;
            credit      <= '0;
          end else if (timeout) begin
            err    <= 1'b1;
            credit <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.vm_nickel   = vm_nickel;
  assign bus.vm_dime     = vm_dime;
  assign bus.done_valid  = done_valid;
  assign bus.done_id     = done_id;
  assign bus.done_change = done_change;
  assign bus.busy        = (state != IDLE);
  assign bus.err         = err;
endmodule

// File: tb/tb_vending_coin_arbiter.sv
// Bench for vending_coin_arbiter: directed scenarios plus a randomized run scored
// against a cents-and-cycles session model and an emulated downstream vending FSM.
module tb_vending_coin_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vending_coin_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus ();

  vending_coin_arbiter #(.N_REQ(N), .ID_W(IDW), .DISP_TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Emulated vending FSM: dispenses the cycle after its 20th cent arrives.
  int fsm_cents     = 0;
  bit fsm_disp      = 1'b0;
  bit disp_suppress = 1'b0;
  bit disp_force    = 1'b0;

  // Session model: who owns the machine, cents paid, when it frees up.
  int m_owner   = -1;
  int m_paid    = 0;
  int m_rr      = 0;
  int m_free_at = -1;
  int pulse_at[int];
  int done_at[int];

  logic [N-1:0]   exp_ready;
  logic           exp_nk, exp_dm, exp_dv, exp_dch, exp_busy;
  logic [IDW-1:0] exp_did;

  task automatic clear_model();
    m_owner = -1; m_paid = 0; m_rr = 0; m_free_at = -1;
    pulse_at.delete(); done_at.delete();
    fsm_cents = 0; fsm_disp = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0; bus.req_dime = '0; bus.vm_dispense = 1'b0;
    @(posedge clock); #1; cyc++;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] d);
    int code;
    bus.req_valid   = v;
    bus.req_dime    = d;
    bus.vm_dispense = disp_force | (fsm_disp & ~disp_suppress);
    if (m_free_at >= 0 && cyc >= m_free_at) begin
      m_owner = -1; m_free_at = -1; m_paid = 0;
    end
    exp_ready = '0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int s = (m_rr + k) % N;
        if (v[s]) begin exp_ready[s] = 1'b1; break; end
      end
    end else if (m_free_at < 0) begin
      exp_ready[m_owner] = 1'b1;
    end
    code   = pulse_at.exists(cyc) ? pulse_at[cyc] : 0;
    exp_nk = (code == 1);
    exp_dm = (code == 2);
    exp_dv = done_at.exists(cyc);
    code   = exp_dv ? done_at[cyc] : 0;
    exp_did  = IDW'(code / 2);
    exp_dch  = (code % 2) == 1;
    exp_busy = (m_owner >= 0);
    #2;
  endtask

  task automatic advance();
    logic [N-1:0] acc;
    acc = bus.req_valid & exp_ready;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (m_owner < 0) begin m_owner = i; m_rr = (i + 1) % N; m_paid = 0; end
        m_paid += bus.req_dime[i] ? 10 : 5;
        pulse_at[cyc + 1] = bus.req_dime[i] ? 2 : 1;
        if (m_paid >= 20) begin
          m_free_at = cyc + 3;
          done_at[cyc + 3] = i * 2 + ((m_paid == 25) ? 1 : 0);
        end
      end
    end
    fsm_cents += ((bus.vm_nickel === 1'b1) ? 5 : 0) + ((bus.vm_dime === 1'b1) ? 10 : 0);
    fsm_disp = (fsm_cents >= 20);
    if (fsm_disp) fsm_cents = 0;
    @(posedge clock); #1; cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    drive('0, '0);
    checks++;
    if ({bus.vm_nickel, bus.vm_dime, bus.done_valid, bus.done_change, bus.busy, bus.err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got nk/dm/dv/dch/busy/err=%b, want 000000",
               {bus.vm_nickel, bus.vm_dime, bus.done_valid, bus.done_change, bus.busy, bus.err});
    end
    checks++;
    if (bus.done_id !== '0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL reset_id_ready: got id=%0d ready=%b, want 0 and 0000", bus.done_id, bus.req_ready);
    end
    drive(4'b0110, '0);
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL reset_first_grant: got ready=%b, want 0010", bus.req_ready);
    end
  endtask

  task automatic test_nickels();
    logic [9:0] nk_bits = '0;
    logic [9:0] dm_bits = '0;
    int done_k = -1, done_id = -1, done_ch = -1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive((k < 4) ? 4'b0001 : 4'b0000, '0);
      if (k < 4) begin
        checks++;
        if (bus.req_ready !== 4'b0001) begin
          errors++;
          $display("FAIL nickels_ready k=%0d: got %b, want 0001", k, bus.req_ready);
        end
      end
      nk_bits[k] = bus.vm_nickel;
      dm_bits[k] = bus.vm_dime;
      if (bus.done_valid === 1'b1 && done_k < 0) begin
        done_k = k; done_id = int'(bus.done_id); done_ch = int'(bus.done_change);
      end
      advance();
    end
    checks++;
    if (nk_bits !== 10'b0000011110 || dm_bits !== '0) begin
      errors++;
      $display("FAIL nickels_pulses: got nickel=%b dime=%b, want 0000011110 and 0", nk_bits, dm_bits);
    end
    checks++;
    if (done_k != 6 || done_id != 0 || done_ch != 0) begin
      errors++;
      $display("FAIL nickels_done: got cycle=%0d id=%0d change=%0d, want 6 0 0", done_k, done_id, done_ch);
    end
  endtask

  task automatic test_overpay();
    int nk = 0, dm = 0, both = 0, dv_cnt = 0, done_k = -1, done_id = -1, done_ch = -1;
    logic [N-1:0] dimes [3] = '{4'b0000, 4'b0100, 4'b0100};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive((k < 3) ? 4'b0100 : 4'b0000, (k < 3) ? dimes[k] : 4'b0000);
      nk += int'(bus.vm_nickel);
      dm += int'(bus.vm_dime);
      if (bus.vm_nickel === 1'b1 && bus.vm_dime === 1'b1) both++;
      if (bus.done_valid === 1'b1) begin
        dv_cnt++;
        if (done_k < 0) begin done_k = k; done_id = int'(bus.done_id); done_ch = int'(bus.done_change); end
      end
      advance();
    end
    checks++;
    if (nk != 1 || dm != 2 || both != 0) begin
      errors++;
      $display("FAIL overpay_pulses: got nickels=%0d dimes=%0d both=%0d, want 1 2 0", nk, dm, both);
    end
    checks++;
    if (done_k != 5 || done_id != 2 || done_ch != 1 || dv_cnt != 1) begin
      errors++;
      $display("FAIL overpay_done: got cycle=%0d id=%0d change=%0d count=%0d, want 5 2 1 1",
               done_k, done_id, done_ch, dv_cnt);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int got = 0;
    bit overlap = 1'b0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(4'b0011, 4'b0011);
      if ($countones(bus.req_ready) > 1) overlap = 1'b1;
      if (bus.done_valid === 1'b1) order.push_back(int'(bus.done_id));
      advance();
    end
    foreach (order[i]) got = got * 10 + order[i] + 1;
    checks++;
    if (overlap) begin
      errors++;
      $display("FAIL rr_overlap: got more than one req_ready bit, want at most one");
    end
    checks++;
    if (order.size() != 4 || got != 1212) begin
      errors++;
      $display("FAIL rr_order: got %0d sales coded %0d, want 4 sales coded 1212 (ids 0,1,0,1)", order.size(), got);
    end
  endtask

  task automatic test_lock();
    int done_k = -1, done_id = -1, acc1 = -1;
    bit early = 1'b0;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      if (k == 0)               drive(4'b1000, '0);
      else if (k >= 3 && k < 6) drive(4'b1010, '0);
      else                      drive(4'b0010, '0);
      if (bus.done_valid === 1'b1 && done_k < 0) begin done_k = k; done_id = int'(bus.done_id); end
      if (done_k < 0 && bus.req_ready[1] === 1'b1) early = 1'b1;
      if (acc1 < 0 && bus.req_ready[1] === 1'b1) acc1 = k;
      advance();
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL lock_stall: got req_ready[1]=1 before slot 3 sale, want 0");
    end
    checks++;
    if (done_k != 8 || done_id != 3) begin
      errors++;
      $display("FAIL lock_done: got cycle=%0d id=%0d, want 8 3", done_k, done_id);
    end
    checks++;
    if (acc1 < done_k || acc1 < 0) begin
      errors++;
      $display("FAIL lock_handover: got slot 1 accepted at %0d, want at or after %0d", acc1, done_k);
    end
  endtask

  task automatic test_timeout();
    int err_k = -1, dv_cnt = 0;
    do_reset();
    disp_suppress = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive((k < 2) ? 4'b0001 : 4'b0000, 4'b0001);
      if (bus.err === 1'b1 && err_k < 0) err_k = k;
      if (bus.done_valid === 1'b1) dv_cnt++;
      advance();
    end
    drive('0, '0);
    checks++;
    if (err_k != 2 + TO + 1 || dv_cnt != 0) begin
      errors++;
      $display("FAIL timeout_err: got err at %0d done count %0d, want %0d and 0", err_k, dv_cnt, 2 + TO + 1);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_after: got busy=%b err=%b, want 0 1", bus.busy, bus.err);
    end
    disp_suppress = 1'b0;
  endtask

  task automatic test_spurious_reset();
    int dv_cnt = 0;
    bit busy_seen = 1'b0;
    do_reset();
    disp_force = 1'b1;
    drive('0, '0);
    advance();
    disp_force = 1'b0;
    drive('0, '0);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_err: got err=%b busy=%b, want 1 0", bus.err, bus.busy);
    end
    do_reset();
    drive('0, '0);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got err=%b after reset, want 0", bus.err);
    end
    advance();
    drive(4'b0001, 4'b0000); advance();
    drive(4'b0001, 4'b0001); advance();
    drive('0, '0);
    busy_seen = (bus.busy === 1'b1);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    clear_model();
    drive('0, '0);
    checks++;
    if (!busy_seen || {bus.req_ready, bus.vm_nickel, bus.vm_dime, bus.done_valid, bus.done_id,
                       bus.done_change, bus.busy, bus.err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy_before=%b ready=%b nk=%b dm=%b dv=%b busy=%b err=%b, want 1 then all 0",
               busy_seen, bus.req_ready, bus.vm_nickel, bus.vm_dime, bus.done_valid, bus.busy, bus.err);
    end
    for (int k = 0; k < 6; k++) begin
      advance();
      drive('0, '0);
      if (bus.done_valid === 1'b1 || bus.busy === 1'b1) dv_cnt++;
    end
    checks++;
    if (dv_cnt != 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d cycles with done_valid or busy, want 0", dv_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(N'($urandom_range(0, 15)), N'($urandom));
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++;
        $display("FAIL rnd_ready cyc=%0d: got %b, want %b", cyc, bus.req_ready, exp_ready);
      end
      checks++;
      if ({bus.vm_nickel, bus.vm_dime} !== {exp_nk, exp_dm}) begin
        errors++;
        $display("FAIL rnd_pulse cyc=%0d: got nk/dm=%b%b, want %b%b", cyc, bus.vm_nickel, bus.vm_dime, exp_nk, exp_dm);
      end
      checks++;
      if (bus.done_valid !== exp_dv || (exp_dv && {bus.done_id, bus.done_change} !== {exp_did, exp_dch})) begin
        errors++;
        $display("FAIL rnd_done cyc=%0d: got v=%b id=%0d ch=%b, want v=%b id=%0d ch=%b",
                 cyc, bus.done_valid, bus.done_id, bus.done_change, exp_dv, exp_did, exp_dch);
      end
      checks++;
      if (bus.busy !== exp_busy || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL rnd_status cyc=%0d: got busy=%b err=%b, want %b 0", cyc, bus.busy, bus.err, exp_busy);
      end
      advance();
    end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_dime = '0; bus.vm_dispense = 1'b0;
    test_reset();
    test_nickels();
    test_overpay();
    test_round_robin();
    test_lock();
    test_timeout();
    test_spurious_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by time limit");
    $fatal(1);
  end
endmodule

// File: doc/vending_coin_arbiter.md
# vending_coin_arbiter

Shares one 5/10/15/20-cent vending FSM (nickel/dime pulse inputs, one-cycle dispense output) between N_REQ coin slots. Round-robin arbitration picks a slot; that slot owns the machine until its purchase dispenses. The block forwards coins as registered one-cycle pulses and tracks credit itself. On each sale it reports which slot bought the item and whether a nickel of change is owed.

## Interface
- N_REQ, default 4: number of coin slots, 2..16.
- ID_W, default 2: requester-id width, equals clog2(N_REQ).
- DISP_TIMEOUT, default 4: cycles allowed in WAIT_DISP for vm_dispense before an error is raised.
- clock  in  1  sole clock, rising-edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  N_REQ  slot i offers a coin.
- req_dime  in  N_REQ  coin type for slot i: 1 = dime, 0 = nickel. Only meaningful when req_valid[i] is high.
- req_ready  out  N_REQ  slot i's coin is accepted this cycle when req_valid[i] & req_ready[i].
- vm_nickel  out  1  registered one-cycle pulse to the vending FSM.
- vm_dime  out  1  registered one-cycle pulse to the vending FSM.
- vm_dispense  in  1  the vending FSM's dispense output.
- done_valid  out  1  one-cycle sale-complete pulse.
- done_id  out  ID_W  slot that completed the sale; valid while done_valid is high.
- done_change  out  1  1 when 25 cents was paid, so a nickel of change is owed; valid while done_valid is high.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  sticky error flag; cleared only by reset.

## Operation
- **States:** IDLE, ACTIVE, WAIT_DISP.
- **credit:** 3-bit register, counted in nickels.
- **owner:** ID_W-bit register.
- **rr_ptr:** ID_W-bit round-robin pointer.
- **IDLE, arbitration:**
  - The winner is the first i with req_valid[i] high, searching from rr_ptr upward and wrapping.
  - req_ready is high for the winner only.
- **IDLE, on accept:**
  - owner = winner; rr_ptr = winner+1, wrapping modulo N_REQ.
  - credit = 1 for a nickel, 2 for a dime.
  - Next state is ACTIVE.
- **ACTIVE:**
  - req_ready is high only for bit owner. Every other slot stalls.
  - On accept, new = credit + (dime ? 2 : 1).
  - If new >= 4: go to WAIT_DISP and latch done_change = (new == 5).
  - Otherwise: credit = new and stay in ACTIVE.
- **Every accepted coin:** drives exactly one pulse on vm_nickel or vm_dime in the following cycle. The two pulses are never high together.
- **WAIT_DISP:**
  - All req_ready are low.
  - When vm_dispense is seen: done_valid pulses in the next cycle with done_id = owner; credit is cleared; next state is IDLE.
  - If vm_dispense has not been seen after DISP_TIMEOUT cycles: set err and go to IDLE with no done_valid pulse.
- **Spurious dispense:** vm_dispense high in IDLE or ACTIVE sets err. State and credit are unchanged.
- **No refund path:** an owner that stops inserting coins holds ACTIVE indefinitely, matching the vending FSM, which has no abort.
- **Reset values:** state IDLE; credit, owner and rr_ptr 0; every output 0, including err.
- **Reset mid-session:** a partially paid session is discarded and no done_valid is produced. The downstream FSM is reset by the same reset signal.

## Timing
- Coin accepted at cycle t → vm_nickel or vm_dime high at t+1 → vending FSM state updates at the end of t+1.
- A completing coin accepted at t → vm_dispense expected at t+2 → done_valid at t+3.
- The block is in IDLE at t+3, so a new coin can be accepted at t+3.
- The owner can insert back-to-back coins in consecutive cycles while in ACTIVE.
- req_ready is a combinational function of state, owner, rr_ptr and req_valid. It never depends on vm_dispense.
- The WAIT_DISP timeout counter starts at 0 on entry. err rises in the cycle after the counter reaches DISP_TIMEOUT.

## Test plan
- **Single-slot nickels:** slot 0 sends 4 nickels in consecutive cycles → vm_nickel pulses for 4 cycles; then done_valid=1, done_id=0, done_change=0, exactly 3 cycles after the 4th accept.
- **Overpay:** slot 2 sends nickel, dime, dime, i.e. 3, then 5 nickels of credit → done_valid with done_id=2 and done_change=1; vm_dime pulses twice.
- **Round-robin:** slots 0 and 1 both hold req_valid continuously and each completes 2 dimes → the sales complete in the order 0, 1, 0, 1; no overlap of req_ready.
- **Lock:** slot 3 owns the session at credit 1 while slot 1 holds req_valid → req_ready[1] stays 0 until slot 3's done_valid, then slot 1 is accepted in the same cycle done_valid is high or later.
- **Dispense timeout:** vm_dispense is held at 0 after a completing coin → err=1 exactly DISP_TIMEOUT+1 cycles after entering WAIT_DISP; no done_valid; busy=0 afterwards.
- **Spurious dispense and reset:** vm_dispense pulsed in IDLE → err=1. Reset asserted in ACTIVE at credit 3 → all outputs 0 in the next cycle and no done_valid.
